// File: rtl/mem_stall_ctrl.sv
// Memory-stage stall controller: holds EX/MEM and the upstream stages while a load/store is in flight.
// Optional watchdog compiled in with `define MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_stall_ctrl #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic        mem_ack,
    input  logic        mem_done,
    output logic        mem_req,
    output logic        mem_req_wr,
    output logic        stall_XM,
    output logic        stall_up,
    output logic        bubble_MW,
    output logic        rd_capture,
    output logic [15:0] stall_cnt,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETIRE = 2'd3
    } state_t;

    state_t state;
    logic   wr_lat;
    logic   in_access;
    logic   timeout_hit;

    assign in_access = (state == ISSUE) || (state == WAIT);

    // Stall is combinational so EX/MEM never advances in the cycle a memory op first appears.
    assign stall_XM   = ((state == IDLE) && mem_en) || in_access;
    assign stall_up   = stall_XM;
    assign bubble_MW  = stall_XM;
    assign mem_req    = (state == ISSUE);
    assign mem_req_wr = wr_lat;
    assign rd_capture = !wr_lat && !timeout_hit &&
                        (((state == ISSUE) && mem_ack && mem_done) ||
                         ((state == WAIT) && mem_done));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_lat    <= 1'b0;
            stall_cnt <= 16'h0000;
        end else begin
            if (stall_XM) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (timeout_hit) begin
                state <= RETIRE;
            end else begin
                case (state)
                    IDLE: begin
                        if (mem_en) begin
                            state  <= ISSUE;
                            wr_lat <= mem_wr;
                        end
                    end
                    ISSUE: begin
                        if (mem_ack) begin
                            state <= mem_done ? RETIRE : WAIT;
                        end
                    end
                    WAIT: begin
                        if (mem_done) begin
                            state <= RETIRE;
                        end
                    end
                    RETIRE:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic [7:0] wd_inc;

    // Fires during the cycle that would bring the count up to the limit.
    assign wd_inc      = wd_cnt + 8'd1;
    assign timeout_hit = in_access && (wd_inc == TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt      <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if ((state == IDLE) && mem_en) begin
                wd_cnt <= 8'd0;
            end else if (in_access) begin
                wd_cnt <= wd_inc;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic timeout_unused;

    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
    assign timeout_unused = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench for mem_stall_ctrl: stimulus queues expected transaction summaries,
// a monitor rebuilds each stall window from the outputs and compares.
module tb_mem_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic        mem_wr;
    logic        mem_ack;
    logic        mem_done;
    logic        mem_req;
    logic        mem_req_wr;
    logic        stall_XM;
    logic        stall_up;
    logic        bubble_MW;
    logic        rd_capture;
    logic [15:0] stall_cnt;
    logic        timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int stalls;
        int reqs;
        int caps;
        int wr;
        int cnt;
        int gap;
    } txn_t;

    txn_t sb[$];

    logic        obs_stall;
    logic        obs_req;
    logic        obs_cap;
    logic        obs_req_wr;
    logic        obs_tmo;
    logic [15:0] obs_cnt;

    mem_stall_ctrl #(.TIMEOUT_CYCLES(8'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_ack    (mem_ack),
        .mem_done   (mem_done),
        .mem_req    (mem_req),
        .mem_req_wr (mem_req_wr),
        .stall_XM   (stall_XM),
        .stall_up   (stall_up),
        .bubble_MW  (bubble_MW),
        .rd_capture (rd_capture),
        .stall_cnt  (stall_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, snapshots outputs mid-cycle, returns just after the next edge.
    task automatic applyStimulus(input logic en, input logic wr, input logic ack, input logic done);
        mem_en   = en;
        mem_wr   = wr;
        mem_ack  = ack;
        mem_done = done;
        #3;
        obs_stall  = stall_XM;
        obs_req    = mem_req;
        obs_cap    = rd_capture;
        obs_req_wr = mem_req_wr;
        obs_tmo    = timeout_err;
        obs_cnt    = stall_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic expectTxn(input int stalls, input int reqs, input int caps,
                             input int wr, input int cnt, input int gap);
        txn_t t;
        t.stalls = stalls;
        t.reqs   = reqs;
        t.caps   = caps;
        t.wr     = wr;
        t.cnt    = cnt;
        t.gap    = gap;
        sb.push_back(t);
    endtask

    task automatic resetDut();
        rst      = 1'b1;
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        mem_ack  = 1'b0;
        mem_done = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: a transaction is one contiguous run of stall_XM, closed by the first non-stall cycle.
    int   m_stalls, m_ups, m_bubbles, m_reqs, m_caps, m_gap, m_gap_seen;
    logic m_wr;
    bit   m_wr_set, m_wr_bad, m_in;
    txn_t m_exp;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            m_in  = 1'b0;
            m_gap = 1000;
        end else if (stall_XM) begin
            if (!m_in) begin
                m_in       = 1'b1;
                m_gap_seen = m_gap;
                m_stalls   = 0;
                m_ups      = 0;
                m_bubbles  = 0;
                m_reqs     = 0;
                m_caps     = 0;
                m_wr_set   = 1'b0;
                m_wr_bad   = 1'b0;
                m_wr       = 1'b0;
            end
            m_stalls++;
            if (stall_up)   m_ups++;
            if (bubble_MW)  m_bubbles++;
            if (mem_req)    m_reqs++;
            if (rd_capture) m_caps++;
            if (mem_req) begin
                if (!m_wr_set) begin
                    m_wr     = mem_req_wr;
                    m_wr_set = 1'b1;
                end else if (mem_req_wr != m_wr) begin
                    m_wr_bad = 1'b1;
                end
            end
        end else if (m_in) begin
            m_in = 1'b0;
            if (rd_capture) m_caps++;
            m_gap = 1;
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_txn: got a %0d-cycle stall window, expected none", m_stalls);
            end else begin
                m_exp = sb.pop_front();
                checkOutput("txn_stall_cycles", m_stalls, m_exp.stalls);
                checkOutput("txn_stall_up_cycles", m_ups, m_exp.stalls);
                checkOutput("txn_bubble_cycles", m_bubbles, m_exp.stalls);
                checkOutput("txn_req_cycles", m_reqs, m_exp.reqs);
                checkOutput("txn_capture_cycles", m_caps, m_exp.caps);
                checkOutput("txn_stall_cnt", int'(stall_cnt), m_exp.cnt);
                if (m_exp.reqs > 0) begin
                    checkOutput("txn_req_wr", int'(m_wr), m_exp.wr);
                    checkOutput("txn_req_wr_stable", int'(m_wr_bad), 0);
                end
                if (m_exp.gap >= 0) begin
                    checkOutput("txn_gap_cycles", m_gap_seen, m_exp.gap);
                end
            end
        end else begin
            m_gap++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_time_limit: got no finish, expected finish before 2 ms");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        rst      = 1'b1;
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        mem_ack  = 1'b0;
        mem_done = 1'b0;
        #1;
        checkOutput("rst_mem_req", int'(mem_req), 0);
        checkOutput("rst_mem_req_wr", int'(mem_req_wr), 0);
        checkOutput("rst_bubble", int'(bubble_MW), 0);
        checkOutput("rst_rd_capture", int'(rd_capture), 0);
        checkOutput("rst_stall_cnt", int'(stall_cnt), 0);
        checkOutput("rst_timeout_err", int'(timeout_err), 0);
        checkOutput("rst_stall_xm_en0", int'(stall_XM), 0);
        mem_en = 1'b1;
        #1;
        checkOutput("rst_stall_xm_en1", int'(stall_XM), 1);
        checkOutput("rst_stall_up_en1", int'(stall_up), 1);
        @(posedge clk);
        #1;
        checkOutput("rst_stall_cnt_held", int'(stall_cnt), 0);
        resetDut();

        // ack/done while idle must be ignored
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("idle_ignore_cap", int'(obs_cap), 0);
        checkOutput("idle_ignore_req", int'(obs_req), 0);
        checkOutput("idle_ignore_stall", int'(obs_stall), 0);

        // Load hit
        expectTxn(2, 1, 1, 0, 2, -1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("load_detect_stall", int'(obs_stall), 1);
        checkOutput("load_detect_req", int'(obs_req), 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("load_issue_cap", int'(obs_cap), 1);
        checkOutput("load_issue_req", int'(obs_req), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("load_retire_stall", int'(obs_stall), 0);
        checkOutput("load_retire_cap", int'(obs_cap), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("load_stall_cnt", int'(obs_cnt), 2);

        // Store: ack after 3 cycles, done 2 cycles after ack; mem_wr drops after issue
        resetDut();
        expectTxn(7, 4, 0, 1, 7, -1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("store_stall_cnt", int'(obs_cnt), 7);
        checkOutput("store_wr_lat_kept", int'(obs_req_wr), 1);

        resetDut();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_clears_wr_lat", int'(obs_req_wr), 0);

        // Back-to-back load then store, one RETIRE cycle between
        resetDut();
        expectTxn(2, 1, 1, 0, 2, -1);
        expectTxn(3, 1, 0, 1, 5, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b_retire_stall", int'(obs_stall), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset pulse while in WAIT abandons the load
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        mem_en   = 1'b0;
        mem_ack  = 1'b0;
        mem_done = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_stall_xm", int'(stall_XM), 0);
        checkOutput("midrst_mem_req", int'(mem_req), 0);
        checkOutput("midrst_stall_cnt", int'(stall_cnt), 0);
        mem_done = 1'b1;
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("midrst_late_done_cap", int'(obs_cap), 0);
        checkOutput("midrst_late_done_stall", int'(obs_stall), 0);
        checkOutput("midrst_cnt_after", int'(stall_cnt), 0);

`ifdef MEM_TIMEOUT_EN
        // Watchdog: ack never arrives, limit of 4 ISSUE cycles
        resetDut();
        expectTxn(5, 4, 0, 0, 5, -1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("tmo_err_before_edge", int'(obs_tmo), 0);
        checkOutput("tmo_err_set", int'(timeout_err), 1);
        checkOutput("tmo_retire_req", int'(mem_req), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("tmo_err_sticky", int'(timeout_err), 1);
        resetDut();
        checkOutput("tmo_err_cleared", int'(timeout_err), 0);
`else
        // Counter wrap: stay in ISSUE for 65535 stalled cycles, then one more
        resetDut();
        expectTxn(65537, 65536, 1, 0, 1, -1);
        for (int i = 0; i < 65535; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_cnt_ffff", int'(stall_cnt), 65535);
        checkOutput("wrap_no_timeout", int'(timeout_err), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_cnt_zero", int'(stall_cnt), 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
`endif

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8'd32, sets the watchdog limit in cycles (used only when the watchdog is compiled in).
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, reset: asynchronous, active-high.
REQ-004 Port mem_en, input, 1, the EX/MEM-stage memory enable (the instruction now in EX/MEM accesses memory).
REQ-005 Port mem_wr, input, 1, the EX/MEM-stage write flag: 1 = store, 0 = load.
REQ-006 Port mem_ack, input, 1, the memory accepted the request.
REQ-007 Port mem_done, input, 1, the memory finished the accepted access.
REQ-008 Port mem_req, output, 1, request to memory.
REQ-009 Port mem_req_wr, output, 1, write qualifier for mem_req.
REQ-010 Port stall_XM, output, 1, drives EXMEM_stall (holds the EX/MEM register).
REQ-011 Port stall_up, output, 1, holds the fetch, IF/ID and ID/EX stages.
REQ-012 Port bubble_MW, output, 1, injects a no-op into MEM/WB (regWrite off, wr off).
REQ-013 Port rd_capture, output, 1, latches the memory read data into MEM/WB.
REQ-014 Port stall_cnt, output, 16, count of stalled cycles.
REQ-015 Port timeout_err, output, 1, sticky watchdog error flag.

Function
REQ-016 The block SHALL implement the FSM states IDLE, ISSUE, WAIT and RETIRE, encoded in 2 bits.
REQ-017 From IDLE the FSM SHALL go to ISSUE when mem_en=1, and SHALL stay in IDLE otherwise.
REQ-018 On the IDLE->ISSUE edge the block SHALL latch mem_wr into wr_lat; mem_req_wr SHALL equal wr_lat.
- mem_req_wr stays stable for the whole transaction.
REQ-019 mem_req SHALL be 1 only in the ISSUE state and SHALL be held until mem_ack=1.
REQ-020 From ISSUE:
- mem_ack=1 and mem_done=1 -> RETIRE;
- mem_ack=1 and mem_done=0 -> WAIT;
- mem_ack=0 -> stay in ISSUE.
REQ-021 From WAIT the FSM SHALL go to RETIRE on mem_done=1, and SHALL stay in WAIT otherwise.
REQ-022 From RETIRE the FSM SHALL go to IDLE unconditionally.
- One RETIRE cycle lets the EX/MEM register advance.
- A back-to-back memory op is therefore seen in IDLE on the next cycle.
REQ-023 stall_XM SHALL equal (IDLE & mem_en) | ISSUE | WAIT.
- This is combinational, so the EX/MEM register never advances in the same cycle a memory op arrives.
REQ-024 stall_up SHALL equal stall_XM.
REQ-025 bubble_MW SHALL equal stall_XM.
REQ-026 rd_capture SHALL be 1 for exactly one cycle: the cycle mem_done=1 is sampled in ISSUE or WAIT while wr_lat=0.
REQ-027 mem_done or mem_ack seen in IDLE or RETIRE SHALL be ignored.
REQ-028 stall_cnt SHALL increment by 1 on every cycle with stall_XM=1 and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-029 Minimum transaction latency (ack and done in the first ISSUE cycle) SHALL be:
- 2 stall cycles (IDLE-detect plus ISSUE);
- then 1 RETIRE cycle.

Reset
REQ-030 rst=1 SHALL asynchronously force the FSM to IDLE and clear wr_lat, stall_cnt, the watchdog counter and timeout_err, with no clock edge needed.
REQ-031 After reset these outputs SHALL be 0: mem_req, mem_req_wr, bubble_MW, rd_capture, stall_cnt, timeout_err.
REQ-032 After reset, stall_XM and stall_up SHALL equal mem_en (IDLE term only).
REQ-033 A reset asserted mid-transaction SHALL abandon the transaction with no RETIRE and no rd_capture.

Configuration
REQ-034 When MEM_TIMEOUT_EN is defined, the block SHALL include an 8-bit watchdog counter.
- The counter clears on entry to ISSUE and increments each ISSUE/WAIT cycle.
- When the counter reaches TIMEOUT_CYCLES, the block SHALL set timeout_err (sticky until reset) and SHALL force the next state to RETIRE with rd_capture=0.
REQ-035 When MEM_TIMEOUT_EN is not defined, the counter SHALL be absent and timeout_err SHALL be tied to 0.
- The FSM waits indefinitely for mem_ack/mem_done.

Verification
REQ-036 Load hit: mem_en=1, mem_wr=0, then ack=done=1 in the first ISSUE cycle -> stall_XM high 2 cycles, rd_capture high 1 cycle, RETIRE, IDLE; stall_cnt=2.
REQ-037 Store with 3-cycle ack delay and done 2 cycles later -> mem_req high 4 cycles, mem_req_wr=1 throughout, rd_capture never high, stall_cnt=7.
REQ-038 Back-to-back load then store -> two separate transactions separated by exactly one RETIRE cycle with stall_XM=0.
REQ-039 rst pulsed while in WAIT -> FSM in IDLE immediately; a later mem_done=1 causes no rd_capture; stall_cnt=0.
REQ-040 Wrap: stall_cnt preloaded via 65535 stalled cycles, then 1 more -> stall_cnt=16'h0000.
REQ-041 With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4 and mem_ack stuck at 0 -> timeout_err=1 after 4 ISSUE cycles, RETIRE, IDLE; timeout_err stays 1 until rst.
